// File: rtl/net_res_pkg.sv
// Shared encodings for the net resolver: 4-state value codes, net kinds, FSM states.
package net_res_pkg;

  localparam logic [1:0] L4_0 = 2'b00;
  localparam logic [1:0] L4_1 = 2'b01;
  localparam logic [1:0] L4_Z = 2'b10;
  localparam logic [1:0] L4_X = 2'b11;

  typedef enum logic [1:0] {
    NK_WIRE = 2'd0,
    NK_WAND = 2'd1,
    NK_WOR  = 2'd2
  } net_kind_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVEN   = 2'd1,
    CONFLICT = 2'd2
  } state_t;

endpackage

// File: rtl/net_res_fn.sv
// Combinational resolution of N_DRV 4-state drivers into a single net value.
module net_res_fn
  import net_res_pkg::*;
#(
  parameter int        N_DRV    = 4,
  parameter net_kind_t NET_KIND = NK_WIRE
) (
  input  logic [2*N_DRV-1:0] drv_val,
  output logic [1:0]         res_val,
  output logic               raw_conflict,
  output logic               any_active
);

  logic has0, has1, hasx;

  // Summarise which values appear on the drivers, then apply the net kind's priority.
  always_comb begin
    has0 = 1'b0;
    has1 = 1'b0;
    hasx = 1'b0;
    for (int i = 0; i < N_DRV; i++) begin
      case (drv_val[2*i +: 2])
        L4_0:    has0 = 1'b1;
        L4_1:    has1 = 1'b1;
        L4_X:    hasx = 1'b1;
        default: ;
      endcase
    end
    any_active   = has0 | has1 | hasx;
    // Conflict is kind-independent: wand/wor still flag a 0/1 fight.
    raw_conflict = hasx | (has0 & has1);
    res_val      = L4_Z;
    case (NET_KIND)
      NK_WAND: begin
        if (has0)      res_val = L4_0;
        else if (hasx) res_val = L4_X;
        else if (has1) res_val = L4_1;
      end
      NK_WOR: begin
        if (has1)      res_val = L4_1;
        else if (hasx) res_val = L4_X;
        else if (has0) res_val = L4_0;
      end
      default: begin
        if (raw_conflict) res_val = L4_X;
        else if (has1)    res_val = L4_1;
        else if (has0)    res_val = L4_0;
      end
    endcase
  end

endmodule

// File: rtl/net_resolver.sv
// Registered net resolver with glitch-filtered conflict detection and event counting.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | every driver is z (or conflict not yet confirmed, all z)
//   DRIVEN   | at least one driver active, no confirmed conflict
//   CONFLICT | raw conflict persisted for GLITCH consecutive cycles
module net_resolver
  import net_res_pkg::*;
#(
  parameter int        N_DRV    = 4,
  parameter net_kind_t NET_KIND = NK_WIRE,
  parameter int        KEEPER   = 1,
  parameter int        GLITCH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*N_DRV-1:0] drv_val,
  input  logic               clr_cnt,
  output logic [1:0]         net_val,
  output logic [1:0]         net_state,
  output logic [15:0]        conflict_cnt,
  output logic               conflict_sticky
);

  localparam logic [3:0] GLITCH_L = 4'(GLITCH);

  logic [1:0]  res_val;
  logic        raw_conflict;
  logic        any_active;
  state_t      state_q, state_d;
  logic [3:0]  run_q, run_d;
  logic        entry;
  logic [1:0]  net_q;
  logic [15:0] cnt_q;
  logic        sticky_q;

  net_res_fn #(
    .N_DRV   (N_DRV),
    .NET_KIND(NET_KIND)
  ) u_fn (
    .drv_val     (drv_val),
    .res_val     (res_val),
    .raw_conflict(raw_conflict),
    .any_active  (any_active)
  );

  // Consecutive-conflict run length, saturating at GLITCH.
  always_comb begin
    run_d = 4'd0;
    if (raw_conflict) run_d = (run_q == GLITCH_L) ? run_q : run_q + 4'd1;
  end

  // Next state: confirmed conflict wins, otherwise follow driver activity.
  always_comb begin
    state_d = any_active ? DRIVEN : IDLE;
    if (run_d == GLITCH_L) state_d = CONFLICT;
    entry = (state_d == CONFLICT) && (state_q != CONFLICT);
  end

  // State, run counter and resolved net register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= 4'd0;
      net_q   <= L4_Z;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      if (!((KEEPER != 0) && (res_val == L4_Z))) net_q <= res_val;
    end
  end

  // Conflict entry counter and sticky flag; an entry on the clearing edge still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 16'd0;
      sticky_q <= 1'b0;
    end else if (clr_cnt) begin
      cnt_q    <= entry ? 16'd1 : 16'd0;
      sticky_q <= entry;
    end else begin
      if (entry && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
      sticky_q <= sticky_q | entry;
    end
  end

  assign net_val         = net_q;
  assign net_state       = state_q;
  assign conflict_cnt    = cnt_q;
  assign conflict_sticky = sticky_q;

endmodule

// File: tb/tb_net_resolver.sv
// Self-checking bench: four resolver variants share one 2-driver stimulus stream.
module tb_net_resolver;
  import net_res_pkg::*;

  localparam logic [1:0] S0 = 2'b00, S1 = 2'b01, SZ = 2'b10, SX = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  drv = 4'b1010;

  logic [1:0]  net_o [4];
  logic [1:0]  st_o  [4];
  logic [15:0] cnt_o [4];
  logic        stk_o [4];

  // Behavioural reference state per DUT.
  logic [1:0]  m_net [4];
  logic [1:0]  m_st  [4];
  int          m_run [4];
  logic [15:0] m_cnt [4];
  logic        m_stk [4];

  // Hand-computed expectations, checked at the next negedge when enabled.
  logic        lit_en  [4];
  logic [1:0]  lit_net [4];
  logic [1:0]  lit_st  [4];
  logic [15:0] lit_cnt [4];
  logic        lit_stk [4];

  logic chk_en       = 1'b0;
  logic preload_flag = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // 0: wire keeper, 1: wand keeper, 2: wor keeper, 3: wire without keeper
  net_resolver #(.N_DRV(2), .NET_KIND(NK_WIRE), .KEEPER(1), .GLITCH(2)) dut_w (
    .clk(clk), .rst(rst), .drv_val(drv), .clr_cnt(clr),
    .net_val(net_o[0]), .net_state(st_o[0]), .conflict_cnt(cnt_o[0]), .conflict_sticky(stk_o[0]));
  net_resolver #(.N_DRV(2), .NET_KIND(NK_WAND), .KEEPER(1), .GLITCH(2)) dut_a (
    .clk(clk), .rst(rst), .drv_val(drv), .clr_cnt(clr),
    .net_val(net_o[1]), .net_state(st_o[1]), .conflict_cnt(cnt_o[1]), .conflict_sticky(stk_o[1]));
  net_resolver #(.N_DRV(2), .NET_KIND(NK_WOR), .KEEPER(1), .GLITCH(2)) dut_o (
    .clk(clk), .rst(rst), .drv_val(drv), .clr_cnt(clr),
    .net_val(net_o[2]), .net_state(st_o[2]), .conflict_cnt(cnt_o[2]), .conflict_sticky(stk_o[2]));
  net_resolver #(.N_DRV(2), .NET_KIND(NK_WIRE), .KEEPER(0), .GLITCH(2)) dut_k (
    .clk(clk), .rst(rst), .drv_val(drv), .clr_cnt(clr),
    .net_val(net_o[3]), .net_state(st_o[3]), .conflict_cnt(cnt_o[3]), .conflict_sticky(stk_o[3]));

  // Reference model: count driver values, apply the resolution tables and event rules.
  int n0, n1, nx, nz;
  logic [1:0] res;
  logic       conf, act, ent;
  logic [1:0] new_st;
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      n0 = 0; n1 = 0; nx = 0; nz = 0;
      for (int i = 0; i < 2; i++) begin
        if (drv[2*i +: 2] == S0) n0++;
        else if (drv[2*i +: 2] == S1) n1++;
        else if (drv[2*i +: 2] == SX) nx++;
        else nz++;
      end
      if (k == 1)      res = (n0 > 0) ? S0 : (nx > 0) ? SX : (n1 > 0) ? S1 : SZ;
      else if (k == 2) res = (n1 > 0) ? S1 : (nx > 0) ? SX : (n0 > 0) ? S0 : SZ;
      else             res = (nz == 2) ? SZ : (nx > 0 || (n0 > 0 && n1 > 0)) ? SX : (n1 > 0) ? S1 : S0;
      conf = (nx > 0) || (n0 > 0 && n1 > 0);
      act  = (nz < 2);
      if (rst) begin
        m_net[k] = SZ; m_st[k] = IDLE; m_run[k] = 0; m_cnt[k] = 16'd0; m_stk[k] = 1'b0;
      end else begin
        if (preload_flag && k == 0) m_cnt[k] = 16'hFFFF;
        m_run[k] = conf ? ((m_run[k] + 1 > 2) ? 2 : m_run[k] + 1) : 0;
        new_st = (m_run[k] == 2) ? CONFLICT : (act ? DRIVEN : IDLE);
        ent = (new_st == CONFLICT) && (m_st[k] != CONFLICT);
        m_st[k] = new_st;
        if (clr) m_cnt[k] = ent ? 16'd1 : 16'd0;
        else if (ent && m_cnt[k] < 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
        m_stk[k] = clr ? ent : (m_stk[k] | ent);
        if (!(res == SZ && k != 3)) m_net[k] = res;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [15:0] act_v, input logic [15:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %h, expected %h", nm, k, $time, act_v, exp_v);
    end
  endtask

  // Compare process: model check every cycle, plus any pending literal expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk("net_val", k, 16'(net_o[k]), 16'(m_net[k]));
        chk("net_state", k, 16'(st_o[k]), 16'(m_st[k]));
        if (!(preload_flag && k == 0)) chk("conflict_cnt", k, cnt_o[k], m_cnt[k]);
        chk("conflict_sticky", k, 16'(stk_o[k]), 16'(m_stk[k]));
        if (lit_en[k]) begin
          chk("lit_net_val", k, 16'(net_o[k]), 16'(lit_net[k]));
          chk("lit_net_state", k, 16'(st_o[k]), 16'(lit_st[k]));
          chk("lit_conflict_cnt", k, cnt_o[k], lit_cnt[k]);
          chk("lit_conflict_sticky", k, 16'(stk_o[k]), 16'(lit_stk[k]));
        end
      end
    end
  end

  task automatic lit(input int k, input logic [1:0] nv, input logic [1:0] sv,
                     input logic [15:0] cv, input logic kv);
    lit_en[k] = 1'b1; lit_net[k] = nv; lit_st[k] = sv; lit_cnt[k] = cv; lit_stk[k] = kv;
  endtask

  // One cycle: let the negedge check run, drive inputs, then pass the next rising edge.
  task automatic step(input logic [3:0] d, input logic r = 1'b0, input logic c = 1'b0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) lit_en[k] = 1'b0;
    drv = d; rst = r; clr = c;
    @(posedge clk);
    #2;
  endtask

  // drv = {driver1, driver0}
  localparam logic [3:0] D_1Z = {S1, SZ};
  localparam logic [3:0] D_10 = {S1, S0};
  localparam logic [3:0] D_0Z = {S0, SZ};
  localparam logic [3:0] D_ZZ = {SZ, SZ};
  localparam logic [3:0] D_Z1 = {SZ, S1};
  localparam logic [3:0] D_00 = {S0, S0};

  logic [3:0] extra [12];

  initial begin
    for (int k = 0; k < 4; k++) lit_en[k] = 1'b0;
    extra[0] = {SX, SZ}; extra[1] = {SZ, S1}; extra[2] = {S0, SZ}; extra[3] = {S1, S1};
    extra[4] = {SX, SX}; extra[5] = {SX, S0}; extra[6] = {SZ, SZ}; extra[7] = {S1, SX};
    extra[8] = {S0, S0}; extra[9] = {S0, S1}; extra[10] = {SZ, SZ}; extra[11] = {SZ, S0};

    step(D_10, 1'b1, 1'b1);
    step(D_10, 1'b1, 1'b1);
    chk_en = 1'b1;
    lit(0, SZ, IDLE, 16'd0, 1'b0);

    step(D_1Z);
    lit(0, S1, DRIVEN, 16'd0, 1'b0);

    step(D_10);
    lit(0, SX, DRIVEN, 16'd0, 1'b0);
    lit(1, S0, DRIVEN, 16'd0, 1'b0);
    lit(2, S1, DRIVEN, 16'd0, 1'b0);
    step(D_10);
    lit(0, SX, CONFLICT, 16'd1, 1'b1);
    lit(1, S0, CONFLICT, 16'd1, 1'b1);
    step(D_10);
    lit(0, SX, CONFLICT, 16'd1, 1'b1);

    step(D_0Z);
    lit(0, S0, DRIVEN, 16'd1, 1'b1);
    step(D_ZZ);
    lit(0, S0, IDLE, 16'd1, 1'b1);
    lit(3, SZ, IDLE, 16'd1, 1'b1);

    step(D_ZZ, 1'b0, 1'b1);
    lit(0, S0, IDLE, 16'd0, 1'b0);

    step(D_10);
    lit(0, SX, DRIVEN, 16'd0, 1'b0);
    step(D_Z1);
    lit(0, S1, DRIVEN, 16'd0, 1'b0);

    step(D_10);
    step(D_10);
    lit(0, SX, CONFLICT, 16'd1, 1'b1);
    step(D_00);
    lit(0, S0, DRIVEN, 16'd1, 1'b1);
    step(D_10);
    step(D_10);
    lit(0, SX, CONFLICT, 16'd2, 1'b1);
    step(D_00);
    step(D_10);
    step(D_10, 1'b0, 1'b1);
    lit(0, SX, CONFLICT, 16'd1, 1'b1);
    step(D_00);

    force dut_w.cnt_q = 16'hFFFF;
    preload_flag = 1'b1;
    #1;
    release dut_w.cnt_q;
    step(D_10);
    preload_flag = 1'b0;
    step(D_10);
    lit(0, SX, CONFLICT, 16'hFFFF, 1'b1);

    step(D_10, 1'b1, 1'b1);
    lit(0, SZ, IDLE, 16'd0, 1'b0);
    lit(1, SZ, IDLE, 16'd0, 1'b0);
    step(D_10);
    lit(0, SX, DRIVEN, 16'd0, 1'b0);
    step(D_10);
    lit(0, SX, CONFLICT, 16'd1, 1'b1);

    step(D_ZZ, 1'b1);
    step(D_ZZ);
    lit(0, SZ, IDLE, 16'd0, 1'b0);

    for (int v = 0; v < 12; v++) step(extra[v]);
    step(D_ZZ);
    step(D_ZZ);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
